pipe_step_ctrl: RTL

PIPE_STEP_CTRL -- requirements
Module: pipe_step_ctrl

---
 rtl/pipe_step_ctrl_pkg.sv | 15 +
 rtl/pipe_step_ctrl_db_sync.sv | 50 +++++
 rtl/pipe_step_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_step_ctrl_pkg.sv
// rtl/pipe_step_ctrl_pkg.sv - shared constants for the pipeline step controller
package pipe_step_ctrl_pkg;

  // 20 ms of stable input at 50 MHz
  localparam logic [19:0] DB_LIMIT_DEF = 20'd1000000;
  // Clock cycles between CPU enables in free-run mode
  localparam logic [23:0] RUN_DIV_DEF  = 24'd5000000;

  // Button debounce FSM encodings
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/pipe_step_ctrl_db_sync.sv
// rtl/pipe_step_ctrl_db_sync.sv - 2-FF synchronizer plus per-bit stability counter
module db_sync
  import pipe_step_ctrl_pkg::*;
#(
  parameter int          WIDTH = 1,
  parameter logic [19:0] LIMIT = DB_LIMIT_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level
);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_2;
  logic [19:0]      stab_cnt [WIDTH];

  // Bring the raw switches into the clock domain
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Each bit follows its input only after LIMIT consecutive disagreeing cycles
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
      for (int i = 0; i < WIDTH; i++) stab_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_2[i] != level[i]) begin
          if (stab_cnt[i] == LIMIT - 20'd1) begin
            level[i]    <= sync_2[i];
            stab_cnt[i] <= '0;
          end else begin
            stab_cnt[i] <= stab_cnt[i] + 20'd1;
          end
        end else begin
          stab_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_step_ctrl.sv
// rtl/pipe_step_ctrl.sv - single-step / free-run CPU clock-enable controller
module pipe_step_ctrl
  import pipe_step_ctrl_pkg::*;
#(
  parameter logic [19:0] DB_LIMIT = DB_LIMIT_DEF,
  parameter logic [23:0] RUN_DIV  = RUN_DIV_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        btn_raw,
  input  logic        run_sw,
  input  logic [4:0]  sw_a_raw,
  input  logic [4:0]  sw_b_raw,
  output logic        cpu_en,
  output logic [4:0]  sw_a,
  output logic [4:0]  sw_b,
  output logic [15:0] step_cnt,
  output logic        btn_level
);

  logic        btn_s1;
  logic        btn_s2;
  logic [1:0]  state;
  logic [19:0] db_cnt;
  logic        press;
  logic        run_db;
  logic [23:0] div;

  db_sync #(.WIDTH(1), .LIMIT(DB_LIMIT)) u_run_sync (
    .clock  (clock),
    .resetn (resetn),
    .raw    (run_sw),
    .level  (run_db)
  );

  db_sync #(.WIDTH(5), .LIMIT(DB_LIMIT)) u_sw_a_sync (
    .clock  (clock),
    .resetn (resetn),
    .raw    (sw_a_raw),
    .level  (sw_a)
  );

  db_sync #(.WIDTH(5), .LIMIT(DB_LIMIT)) u_sw_b_sync (
    .clock  (clock),
    .resetn (resetn),
    .raw    (sw_b_raw),
    .level  (sw_b)
  );

  // Bring the button into the clock domain
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce the button; one press pulse on each accepted press edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      db_cnt    <= '0;
      btn_level <= 1'b0;
      press     <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_s2) begin
            state  <= ST_PRESS_WAIT;
            db_cnt <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!btn_s2) begin
            state <= ST_IDLE;
          end else if (db_cnt == DB_LIMIT - 20'd1) begin
            state     <= ST_HELD;
            btn_level <= 1'b1;
            press     <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 20'd1;
          end
        end
        ST_HELD: begin
          if (!btn_s2) begin
            state  <= ST_RELEASE_WAIT;
            db_cnt <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (btn_s2) begin
            state <= ST_HELD;
          end else if (db_cnt == DB_LIMIT - 20'd1) begin
            state     <= ST_IDLE;
            btn_level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 20'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Issue cpu_en from the divider in run mode or from press pulses in step
  // mode; the divider is held at zero outside run mode so every entry into
  // run mode starts a full period
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div      <= '0;
      cpu_en   <= 1'b0;
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + {15'd0, cpu_en};
      if (run_db) begin
        if (div == RUN_DIV - 24'd1) begin
          div    <= '0;
          cpu_en <= 1'b1;
        end else begin
          div    <= div + 24'd1;
          cpu_en <= 1'b0;
        end
      end else begin
        div    <= '0;
        cpu_en <= press;
      end
    end
  end

endmodule
